fibonacci_checker: RTL and testbench

- Receive-side counterpart to the Fibonacci generator. Consumes the generator's 8-bit term stream and verifies it on the fly.
- Synchronises on the seed pair, then predicts each next term modulo 2^WIDTH and compares it with the sample.
- Reports lock, per-term match/mismatch pulses, a term count, a sticky error and a sticky wrap flag.
- Placed in the Fibonacci test bench or in silicon as a self-check monitor on the generator output bus.

---
 rtl/fib_defs.sv | 17 +
 rtl/fib_sum_stage.sv | 17 +
 rtl/fibonacci_checker.sv | 141 ++++++++++++++
 tb/tb_fibonacci_checker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fib_defs.sv
// Shared definitions for the Fibonacci generator and checker: state
// encodings and default data width / seed values.
package fib_defs;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_START_A = 0;
   localparam int DEF_START_B = 1;
   localparam int DEF_CNT_W   = 8;

   typedef enum logic [1:0] {
      ST_WAIT_A = 2'd0,
      ST_WAIT_B = 2'd1,
      ST_TRACK  = 2'd2,
      ST_FAIL   = 2'd3
   } fib_state_e;

endpackage : fib_defs

// File: rtl/fib_sum_stage.sv
// Combinational WIDTH-bit adder with carry-out: forms the next Fibonacci
// prediction from the two most recent terms.
module fib_sum_stage #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] prev_i,
   input  logic [WIDTH-1:0] cur_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);

   // Add at WIDTH+1 bits so the overflow is visible as carry_o.
   always_comb begin
      {carry_o, sum_o} = {1'b0, prev_i} + {1'b0, cur_i};
   end

endmodule : fib_sum_stage

// File: rtl/fibonacci_checker.sv
// Receive-side monitor for the Fibonacci generator: syncs on the seed pair,
// then predicts each following term modulo 2^WIDTH and flags deviations.
module fibonacci_checker
   import fib_defs::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] START_A = WIDTH'(DEF_START_A),
   parameter logic [WIDTH-1:0] START_B = WIDTH'(DEF_START_B),
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             locked,
   output logic             match,
   output logic             mismatch,
   output logic             error,
   output logic             wrapped,
   output logic [WIDTH-1:0] expected,
   output logic [CNT_W-1:0] term_count,
   output logic [CNT_W-1:0] mismatch_count
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(2);

   fib_state_e       state_q;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] cur_q,  cur_d;
   logic [WIDTH-1:0] sum_d;
   logic             carry_d;
   logic             carry_q;     // overflow of the prediction held in expected_q
   logic             locked_q, match_q, mismatch_q, error_q, wrapped_q;
   logic [WIDTH-1:0] expected_q;
   logic [CNT_W-1:0] term_count_q, mismatch_count_q;

   logic             hit_a, hit_b, hit_exp;

   assign hit_a   = in_valid && (in_data == START_A);
   assign hit_b   = in_valid && (in_data == START_B);
   assign hit_exp = in_valid && (in_data == expected_q);

   // Next values of the term pair; the adder sees them so the prediction
   // for the following term is registered on the same edge as the sample.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // through the case leaves it unassigned and infers a latch.
      prev_d = prev_q;
      cur_d  = cur_q;
      unique case (state_q)
         ST_WAIT_A, ST_FAIL: begin
            if (hit_a) prev_d = in_data;
         end
         ST_WAIT_B: begin
            if (hit_b) cur_d = in_data;
         end
         ST_TRACK: begin
            if (hit_exp) begin
               prev_d = cur_q;
               cur_d  = in_data;
            end
         end
         default: ;
      endcase
   end

   fib_sum_stage #(.WIDTH(WIDTH)) u_sum (
      .prev_i  (prev_d),
      .cur_i   (cur_d),
      .sum_o   (sum_d),
      .carry_o (carry_d)
   );

   // Sync/track state machine with all status outputs registered.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;

      if (reset) begin
         state_q          <= ST_WAIT_A;
         prev_q           <= '0;
         cur_q            <= '0;
         carry_q          <= 1'b0;
         locked_q         <= 1'b0;
         error_q          <= 1'b0;
         wrapped_q        <= 1'b0;
         expected_q       <= '0;
         term_count_q     <= '0;
         mismatch_count_q <= '0;
      end else begin
         unique case (state_q)
            ST_WAIT_A, ST_FAIL: begin
               if (hit_a) state_q <= ST_WAIT_B;
            end
            ST_WAIT_B: begin
               if (hit_b) begin
                  state_q      <= ST_TRACK;
                  locked_q     <= 1'b1;
                  term_count_q <= CNT_SYNC;
                  expected_q   <= sum_d;
                  carry_q      <= carry_d;
               end else if (in_valid && !hit_a) begin
                  state_q <= ST_WAIT_A;
               end
            end
            ST_TRACK: begin
               if (hit_exp) begin
                  match_q    <= 1'b1;
                  expected_q <= sum_d;
                  carry_q    <= carry_d;
                  if (carry_q) wrapped_q <= 1'b1;
                  if (term_count_q != CNT_MAX) term_count_q <= term_count_q + 1'b1;
               end else if (in_valid) begin
                  state_q    <= ST_FAIL;
                  locked_q   <= 1'b0;
                  mismatch_q <= 1'b1;
                  error_q    <= 1'b1;
                  if (mismatch_count_q != CNT_MAX)
                     mismatch_count_q <= mismatch_count_q + 1'b1;
               end
            end
            default: state_q <= ST_WAIT_A;
         endcase
      end
   end

   assign locked         = locked_q;
   assign match          = match_q;
   assign mismatch       = mismatch_q;
   assign error          = error_q;
   assign wrapped        = wrapped_q;
   assign expected       = expected_q;
   assign term_count     = term_count_q;
   assign mismatch_count = mismatch_count_q;

endmodule : fibonacci_checker

// File: tb/tb_fibonacci_checker.sv
// Self-checking bench for fibonacci_checker: a vector table applied through
// a one-deep scoreboard, plus saturation sequences.
module tb_fibonacci_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       locked, match, mismatch, error, wrapped;
   logic [7:0] expected, term_count, mismatch_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fibonacci_checker dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .locked         (locked),
      .match          (match),
      .mismatch       (mismatch),
      .error          (error),
      .wrapped        (wrapped),
      .expected       (expected),
      .term_count     (term_count),
      .mismatch_count (mismatch_count)
   );

   typedef struct {
      logic       rst;
      logic       vld;
      logic [7:0] data;
      logic       lk, m, mm, er, wr;
      int         tc, mc, ex;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic vld, input int data,
                      input logic lk, input logic m, input logic mm,
                      input logic er, input logic wr,
                      input int tc, input int mc, input int ex);
      vec_t v;
      v.rst = rst; v.vld = vld; v.data = 8'(data);
      v.lk = lk; v.m = m; v.mm = mm; v.er = er; v.wr = wr;
      v.tc = tc; v.mc = mc; v.ex = ex;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic vld, input int data);
      reset = rst; in_valid = vld; in_data = 8'(data);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int idx, input vec_t v);
      vec_t e;
      sb.push_back(v);
      drive(v.rst, v.vld, v.data);
      e = sb.pop_front();
      check($sformatf("v%0d.locked", idx),         locked,         e.lk);
      check($sformatf("v%0d.match", idx),          match,          e.m);
      check($sformatf("v%0d.mismatch", idx),       mismatch,       e.mm);
      check($sformatf("v%0d.error", idx),          error,          e.er);
      check($sformatf("v%0d.wrapped", idx),        wrapped,        e.wr);
      check($sformatf("v%0d.term_count", idx),     term_count,     e.tc);
      check($sformatf("v%0d.mismatch_count", idx), mismatch_count, e.mc);
      check($sformatf("v%0d.expected", idx),       expected,       e.ex);
      check($sformatf("v%0d.exclusive", idx),      int'(match && mismatch), 0);
   endtask

   initial begin
      int a, b, n;

      //  rst vld data  lk m mm er wr  tc mc  ex
      // clean stream
      add(1, 0,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   1,   1,0,0, 0,0,   2, 0,   1);
      add(0, 1,   1,   1,1,0, 0,0,   3, 0,   2);
      add(0, 1,   2,   1,1,0, 0,0,   4, 0,   3);
      add(0, 1,   3,   1,1,0, 0,0,   5, 0,   5);
      add(0, 1,   5,   1,1,0, 0,0,   6, 0,   8);
      add(0, 1,   8,   1,1,0, 0,0,   7, 0,  13);
      add(0, 1,  13,   1,1,0, 0,0,   8, 0,  21);
      add(0, 0,  99,   1,0,0, 0,0,   8, 0,  21);
      // continue through the 8-bit wrap
      add(0, 1,  21,   1,1,0, 0,0,   9, 0,  34);
      add(0, 1,  34,   1,1,0, 0,0,  10, 0,  55);
      add(0, 1,  55,   1,1,0, 0,0,  11, 0,  89);
      add(0, 1,  89,   1,1,0, 0,0,  12, 0, 144);
      add(0, 1, 144,   1,1,0, 0,0,  13, 0, 233);
      add(0, 1, 233,   1,1,0, 0,0,  14, 0, 121);
      add(0, 1, 121,   1,1,0, 0,1,  15, 0,  98);
      add(0, 1,  98,   1,1,0, 0,1,  16, 0, 219);
      // corruption and resync; reset overrides a valid sample
      add(1, 1,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   1,   1,0,0, 0,0,   2, 0,   1);
      add(0, 1,   1,   1,1,0, 0,0,   3, 0,   2);
      add(0, 1,   2,   1,1,0, 0,0,   4, 0,   3);
      add(0, 1,   3,   1,1,0, 0,0,   5, 0,   5);
      add(0, 1,   7,   0,0,1, 1,0,   5, 1,   5);
      add(0, 0,   7,   0,0,0, 1,0,   5, 1,   5);
      add(0, 1,   0,   0,0,0, 1,0,   5, 1,   5);
      add(0, 1,   1,   1,0,0, 1,0,   2, 1,   1);
      add(0, 1,   1,   1,1,0, 1,0,   3, 1,   2);
      // garbage before sync, with bubbles
      add(1, 0,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,  55,   0,0,0, 0,0,   0, 0,   0);
      add(0, 0,  77,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   9,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 0,   1,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   9,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   1,   1,0,0, 0,0,   2, 0,   1);
      add(0, 0,   1,   1,0,0, 0,0,   2, 0,   1);
      add(0, 1,   1,   1,1,0, 0,0,   3, 0,   2);
      // reset mid-track
      add(1, 0,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   1,   1,0,0, 0,0,   2, 0,   1);
      add(0, 1,   1,   1,1,0, 0,0,   3, 0,   2);
      add(0, 1,   2,   1,1,0, 0,0,   4, 0,   3);
      add(0, 1,   3,   1,1,0, 0,0,   5, 0,   5);
      add(0, 1,   5,   1,1,0, 0,0,   6, 0,   8);
      add(1, 1,   8,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   0,   0,0,0, 0,0,   0, 0,   0);
      add(0, 1,   1,   1,0,0, 0,0,   2, 0,   1);
      add(0, 1,   1,   1,1,0, 0,0,   3, 0,   2);

      foreach (tbl[i]) step(i, tbl[i]);

      // term_count saturation over a long clean stream
      drive(1, 0, 0);
      drive(0, 1, 0);
      drive(0, 1, 1);
      a = 0; b = 1;
      for (int i = 0; i < 300; i++) begin
         n = (a + b) % 256;
         drive(0, 1, n);
         check($sformatf("sat_tc.match%0d", i), match, 1);
         a = b; b = n;
      end
      check("sat_tc.term_count", term_count, 255);
      check("sat_tc.locked", locked, 1);
      check("sat_tc.error", error, 0);
      check("sat_tc.wrapped", wrapped, 1);
      check("sat_tc.expected", expected, (a + b) % 256);

      // mismatch_count saturation: repeated sync then wrong third term
      drive(1, 0, 0);
      for (int i = 0; i < 260; i++) begin
         drive(0, 1, 0);
         drive(0, 1, 1);
         drive(0, 1, 5);
      end
      check("sat_mc.mismatch_count", mismatch_count, 255);
      check("sat_mc.error", error, 1);
      check("sat_mc.locked", locked, 0);
      drive(0, 0, 0);
      check("sat_mc.mismatch_fall", mismatch, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fibonacci_checker
